// File: rtl/fmul32_pkg.sv
// Shared types and constants for the FMUL32 arbiter, the multiplier wrapper and benches.
package fmul32_pkg;

  localparam int FP32_W   = 32;
  localparam int TAG_ID_W = 3;  // wide enough for the largest supported requester count (8)

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fmul32_arbiter_rr.sv
// Combinational round-robin picker: the first eligible index after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  logic [ID_W-1:0] cand_idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_idx    = '0;
    // Scan lowest priority first so the nearest candidate after ptr overwrites the rest.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand_idx = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (eligible[cand_idx]) begin
        grant       = NUM_REQ'(1) << cand_idx;
        grant_idx   = cand_idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmul32_arbiter.sv
// Shares one fixed-latency FMUL32 between NUM_REQ requesters with round-robin issue.
// Define FMUL_ARB_PERF_EN to add the perf_ops / perf_conflicts counters.
module fmul32_arbiter
  import fmul32_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*32-1:0]     req_a,
  input  logic [NUM_REQ*32-1:0]     req_b,
  input  logic [NUM_REQ*2-1:0]      req_rm,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*32-1:0]     rsp_data,
  output logic                      mul_valid,
  output logic [31:0]               mul_a,
  output logic [31:0]               mul_b,
  output logic [1:0]                mul_rm,
  input  logic [31:0]               mul_res
`ifdef FMUL_ARB_PERF_EN
  ,
  output logic [31:0]               perf_ops,
  output logic [31:0]               perf_conflicts
`endif
);

  logic [NUM_REQ-1:0][FP32_W-1:0] req_a_v, req_b_v, rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0][1:0]        req_rm_v;
  logic [NUM_REQ-1:0]             busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]             eligible, grant, rsp_hs;
  logic [ID_W-1:0]                ptr_q, ptr_d, grant_idx, tail_id;
  logic                           grant_valid, mul_valid_q, mul_valid_d;
  logic [FP32_W-1:0]              mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [1:0]                     mul_rm_q, mul_rm_d;
  tag_t                           tag_q [LATENCY];
  tag_t                           tag_d [LATENCY];
  tag_t                           tail;

  assign req_a_v  = req_a;
  assign req_b_v  = req_b;
  assign req_rm_v = req_rm;

  assign eligible = req_valid & ~busy_q;
  assign rsp_hs   = rsp_valid_q & rsp_ready;
  assign tail     = tag_q[LATENCY-1];
  assign tail_id  = ID_W'(tail.id);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .eligible    (eligible),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    ptr_d       = ptr_q;
    mul_valid_d = grant_valid;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_rm_d    = mul_rm_q;
    busy_d      = (busy_q & ~rsp_hs) | grant;
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    rsp_data_d  = rsp_data_q;
    if (grant_valid) begin
      ptr_d    = grant_idx;
      mul_a_d  = req_a_v[grant_idx];
      mul_b_d  = req_b_v[grant_idx];
      mul_rm_d = req_rm_v[grant_idx];
    end
    tag_d[0].valid = grant_valid;
    tag_d[0].id    = TAG_ID_W'(grant_idx);
    for (int s = 1; s < LATENCY; s++) tag_d[s] = tag_q[s-1];
    // Busy gating guarantees the destination register is empty when its tag arrives.
    if (tail.valid) begin
      rsp_valid_d[tail_id] = 1'b1;
      rsp_data_d[tail_id]  = mul_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_rm_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_rm_q    <= mul_rm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (rst) tag_q[gi] <= '0;
      else     tag_q[gi] <= tag_d[gi];
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_rm    = mul_rm_q;

`ifdef FMUL_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d, perf_conf_q, perf_conf_d;

  always_comb begin
    perf_ops_d  = perf_ops_q + {31'd0, grant_valid};
    perf_conf_d = perf_conf_q + {31'd0, ((eligible & (eligible - 1'b1)) != '0)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q  <= '0;
      perf_conf_q <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  assign perf_ops       = perf_ops_q;
  assign perf_conflicts = perf_conf_q;
`endif

endmodule

// File: tb/tb_fmul32_arbiter.sv
// Scoreboard bench for fmul32_arbiter: directed vectors, expected products hand-computed.
`timescale 1ns/1ps
module tb_fmul32_arbiter;
  import fmul32_pkg::*;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b, rsp_data;
  logic [N*2-1:0]  req_rm;
  logic            mul_valid;
  logic [31:0]     mul_a, mul_b, mul_res;
  logic [1:0]      mul_rm;
`ifdef FMUL_ARB_PERF_EN
  logic [31:0]     perf_ops, perf_conflicts;
`endif

  always #5 clk = ~clk;

  fmul32_arbiter #(.NUM_REQ(N), .LATENCY(L), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm),
    .mul_res(mul_res)
`ifdef FMUL_ARB_PERF_EN
    , .perf_ops(perf_ops), .perf_conflicts(perf_conflicts)
`endif
  );

  // Multiplier model: table of exact FP32 products for the directed operand pairs.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FC00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40000000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
      {32'h40400000, 32'h3F000000}: return 32'h3FC00000;
      {32'hBF800000, 32'h3F800000}: return 32'hBF800000;
      {32'h40800000, 32'h3E800000}: return 32'h3F800000;
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  // Result is sampled by the arbiter on the edge LATENCY cycles after mul_valid rises.
  logic [31:0] mpipe [L-1];
  always @(posedge clk) begin
    mpipe[0] <= mul_valid ? fmodel(mul_a, mul_b) : 32'h0BADF00D;
    for (int s = 1; s < L-1; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_res = mpipe[L-2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [N][$];
  int          iss_q [N][$];
  int          grant_log[$], grant_cyc[$], rsp_log[$];
  logic [N-1:0]   busy_m, rv_prev, hs_prev;
  logic [N*32-1:0] rd_prev;
  logic           mul_due;
  logic [65:0]    mul_exp;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: issue-stage, grant legality, hold stability, latency and data scoreboard.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      busy_m = '0; mul_due = 1'b0; rv_prev = '0; hs_prev = '0; rd_prev = '0;
      for (int k = 0; k < N; k++) iss_q[k].delete();
    end else begin
      check_eq("mul_valid", {63'd0, mul_valid}, {63'd0, mul_due});
      if (mul_due) check_eq("mul_operands", {mul_a, mul_b, mul_rm}, mul_exp);
      checks++;
      if (!$onehot0(req_ready) || ((req_ready & busy_m) != '0)) begin
        errors++;
        $display("FAIL grant_legal cyc=%0d got=%b busy=%b", cyc, req_ready, busy_m);
      end
      mul_due = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          busy_m[k] = 1'b1;
          mul_due   = 1'b1;
          mul_exp   = {req_a[32*k +: 32], req_b[32*k +: 32], req_rm[2*k +: 2]};
          iss_q[k].push_back(cyc);
          grant_log.push_back(k);
          grant_cyc.push_back(cyc);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (rv_prev[k] && !hs_prev[k]) begin
          check_eq($sformatf("rsp_hold%0d", k), {31'd0, rsp_valid[k], rsp_data[32*k +: 32]},
                   {31'd0, 1'b1, rd_prev[32*k +: 32]});
        end
        if (rsp_valid[k] && !rv_prev[k]) begin
          rsp_log.push_back(k);
          if (iss_q[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected%0d cyc=%0d got=1 want=0", k, cyc);
          end else begin
            check_eq($sformatf("rsp_latency%0d", k), 64'(cyc - iss_q[k].pop_front()), 64'(L + 1));
          end
        end
        if (rsp_valid[k] && rsp_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_extra%0d cyc=%0d got=%h want=none", k, cyc, rsp_data[32*k +: 32]);
          end else begin
            check_eq($sformatf("rsp_data%0d", k), {32'd0, rsp_data[32*k +: 32]},
                     {32'd0, exp_q[k].pop_front()});
          end
          busy_m[k] = 1'b0;
        end
      end
      rv_prev = rsp_valid;
      rd_prev = rsp_data;
      hs_prev = rsp_valid & rsp_ready;
    end
  end

  // Issue one operation; called at a falling edge, returns at the falling edge after the grant.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] rm, input logic [31:0] expv);
    bit got = 1'b0;
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    req_rm[2*k +: 2]  = rm;
    exp_q[k].push_back(expv);
    req_valid[k] = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      #1;
      got = req_ready[k];
      @(negedge clk);
    end
    req_valid[k] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL issue_timeout%0d cyc=%0d got=no_grant want=grant", k, cyc);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int n = 0; n < 100 && !idle; n++) begin
      @(negedge clk);
      #3;
      idle = (busy_m == '0) && (rsp_valid == '0);
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle_timeout cyc=%0d got=%b want=0", cyc, busy_m);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_t1 [4] = '{0, 1, 2, 3};
    int exp_t4 [4] = '{3, 0, 1, 2};
    rst = 1'b1; req_valid = '0; rsp_ready = '1;
    req_a = '0; req_b = '0; req_rm = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_mul", {31'd0, mul_valid, mul_a, mul_rm}, 64'd0);
    check_eq("reset_mul_b", {32'd0, mul_b}, 64'd0);
    check_eq("reset_rsp", {60'd0, rsp_valid}, 64'd0);
    check_eq("reset_rsp_data", 64'(rsp_data != '0), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Four-way contention.
    grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
    fork
      issue(0, 32'h3F800000, 32'h40000000, RM_RNE, 32'h40000000);
      issue(1, 32'h40000000, 32'h40000000, RM_RTZ, 32'h40800000);
      issue(2, 32'h3FC00000, 32'h3FC00000, RM_RUP, 32'h40100000);
      issue(3, 32'h40400000, 32'h3F000000, RM_RDN, 32'h3FC00000);
    join
    wait_idle();
    check_eq("t1_grant_count", 64'(grant_log.size()), 64'd4);
    check_eq("t1_rsp_count", 64'(rsp_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check_eq($sformatf("t1_grant_order%0d", i), 64'(grant_log[i]), 64'(exp_t1[i]));
      check_eq($sformatf("t1_grant_cycle%0d", i), 64'(grant_cyc[i] - grant_cyc[0]), 64'(i));
    end
    for (int i = 0; i < 4 && i < rsp_log.size(); i++)
      check_eq($sformatf("t1_rsp_order%0d", i), 64'(rsp_log[i]), 64'(exp_t1[i]));
`ifdef FMUL_ARB_PERF_EN
    check_eq("perf_ops", {32'd0, perf_ops}, 64'd4);
    check_eq("perf_conflicts", {32'd0, perf_conflicts}, 64'd3);
`endif

    // Single op: 1.5 * 2.0.
    issue(0, 32'h3FC00000, 32'h40000000, RM_RNE, 32'h40400000);
    wait_idle();

    // Rounding-mode passthrough: -1.0 * 1.0, rm toward -inf.
    issue(1, 32'hBF800000, 32'h3F800000, RM_RDN, 32'hBF800000);
    wait_idle();

    // Held result on requester 2 while others proceed.
    rsp_ready[2] = 1'b0;
    issue(2, 32'h40800000, 32'h3E800000, RM_RNE, 32'h3F800000);
    grant_log.delete();
    fork
      issue(2, 32'h3F800000, 32'h40000000, RM_RTZ, 32'h40000000);
      fork
        issue(0, 32'h40000000, 32'h40000000, RM_RNE, 32'h40800000);
        issue(1, 32'h3FC00000, 32'h3FC00000, RM_RTZ, 32'h40100000);
        issue(3, 32'h40400000, 32'h3F000000, RM_RUP, 32'h3FC00000);
      join
      begin
        repeat (10) @(negedge clk);
        #1;
        check_eq("t4_held_valid", {63'd0, rsp_valid[2]}, 64'd1);
        check_eq("t4_ready2_before", {63'd0, req_ready[2]}, 64'd0);
        rsp_ready[2] = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t4_ready2_after", {63'd0, req_ready[2]}, 64'd1);
      end
    join
    wait_idle();
    check_eq("t4_grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq($sformatf("t4_grant_order%0d", i), 64'(grant_log[i]), 64'(exp_t4[i]));

    // Reset while requester 3 is in flight.
    issue(3, 32'h3FC00000, 32'h40000000, RM_RNE, 32'h40400000);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < N; k++) exp_q[k].delete();
    @(negedge clk);
    #1;
    check_eq("t5_mul_cleared", {31'd0, mul_valid, mul_a, mul_rm}, 64'd0);
    check_eq("t5_rsp_cleared", {60'd0, rsp_valid}, 64'd0);
    check_eq("t5_rsp_data_cleared", 64'(rsp_data != '0), 64'd0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("t5_late_ignored%0d", n), {60'd0, rsp_valid}, 64'd0);
    end
    @(negedge clk);
    grant_log.delete();
    fork
      issue(3, 32'h3F800000, 32'h40000000, RM_RNE, 32'h40000000);
      issue(0, 32'h40800000, 32'h3E800000, RM_RTZ, 32'h3F800000);
    join
    wait_idle();
    check_eq("t5_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) begin
      check_eq("t5_first_grant", 64'(grant_log[0]), 64'd0);
      check_eq("t5_second_grant", 64'(grant_log[1]), 64'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
